// File: rtl/conv_pkg.sv
// Shared geometry defaults for the 3x3 conv accelerator output path.
// Also holds the OFM collector FSM state encoding.
package conv_pkg;

    localparam int CONV_DATA_W = 25;
    localparam int CONV_OUT_W  = 16;
    localparam int CONV_TI     = 16;
    localparam int CONV_TILE_H = 5;
    localparam int CONV_N_TW   = 4;
    localparam int CONV_N_TH   = 13;
    localparam int CONV_N_CH   = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } ofm_state_e;

endpackage

// File: rtl/ofm_requant.sv
// Combinational requantiser: round, arithmetic shift, optional ReLU, saturate.
// Ports: x (signed DATA_W), shift (0..DATA_W-1), relu, y (signed OUT_W).
module ofm_requant
    import conv_pkg::*;
#(
    parameter int DATA_W = CONV_DATA_W,
    parameter int OUT_W  = CONV_OUT_W
) (
    input  logic signed [DATA_W-1:0] x,
    input  logic        [4:0]        shift,
    input  logic                     relu,
    output logic signed [OUT_W-1:0]  y
);

    localparam logic signed [DATA_W:0] MAX_V =
        (DATA_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [DATA_W:0] MIN_V = ~MAX_V;

    logic signed [DATA_W:0] xe;
    logic signed [DATA_W:0] rnd;
    logic signed [DATA_W:0] sum;
    logic signed [DATA_W:0] q;
    logic signed [DATA_W:0] y_w;

    always_comb begin
        xe  = {x[DATA_W-1], x};
        rnd = '0;
        if (shift != 5'd0)
            rnd = (DATA_W+1)'(1) << (shift - 5'd1);
        // One extra bit keeps x + half-LSB from overflowing.
        sum = xe + rnd;
        q   = sum >>> shift;
        if (relu && q[DATA_W])
            q = '0;
        if (q > MAX_V)
            y_w = MAX_V;
        else if (q < MIN_V)
            y_w = MIN_V;
        else
            y_w = q;
    end

    assign y = y_w[OUT_W-1:0];

endmodule

// File: rtl/ofm_tile_collector.sv
// Collects the tiled two-row conv output stream into raster OFM addresses,
// requantises each pixel and issues up to two buffer writes per cycle.
// Ports: clk, rst_n, start, cfg_ch/shift/relu, ofm_port0/1 (+_v),
//        wr0/wr1 en/addr/data, busy, frame_done, proto_err.
module ofm_tile_collector
    import conv_pkg::*;
#(
    parameter int DATA_W = CONV_DATA_W,
    parameter int OUT_W  = CONV_OUT_W,
    parameter int TI     = CONV_TI,
    parameter int TILE_H = CONV_TILE_H,
    parameter int N_TW   = CONV_N_TW,
    parameter int N_TH   = CONV_N_TH,
    parameter int N_CH   = CONV_N_CH,
    localparam int OFM_W = TI * N_TW,
    localparam int OFM_H = TILE_H * N_TH,
    localparam int AW    = $clog2(N_CH * OFM_H * OFM_W),
    localparam int CHW   = $clog2(N_CH) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic        [CHW-1:0]    cfg_ch,
    input  logic        [4:0]        cfg_shift,
    input  logic                     cfg_relu,
    input  logic signed [DATA_W-1:0] ofm_port0,
    input  logic signed [DATA_W-1:0] ofm_port1,
    input  logic                     ofm_port0_v,
    input  logic                     ofm_port1_v,
    output logic                     wr0_en,
    output logic                     wr1_en,
    output logic        [AW-1:0]     wr0_addr,
    output logic        [AW-1:0]     wr1_addr,
    output logic        [OUT_W-1:0]  wr0_data,
    output logic        [OUT_W-1:0]  wr1_data,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     proto_err
);

    localparam int CW  = (TI > 1) ? $clog2(TI) : 1;
    localparam int RW  = $clog2(TILE_H + 2);
    localparam int TWW = (N_TW > 1) ? $clog2(N_TW) : 1;
    localparam int THW = (N_TH > 1) ? $clog2(N_TH) : 1;

    ofm_state_e state, state_nxt;

    logic [CW-1:0]  c;
    logic [RW-1:0]  r;
    logic [TWW-1:0] tw;
    logic [THW-1:0] th;
    logic [CHW-1:0] ch;

    // strip_base = (ch*OFM_H + th*TILE_H)*OFM_W, row_off = r*OFM_W,
    // col_base = tw*TI; all stepped by constants.
    logic [AW-1:0] strip_base;
    logic [AW-1:0] row_off;
    logic [AW-1:0] col_base;

    logic [CHW-1:0] cfg_ch_q;
    logic [4:0]     cfg_shift_q;
    logic           cfg_relu_q;

    logic dual, collecting, bad_dual, accept, err;
    logic c_last, row_last, tw_last, th_last, ch_last;
    logic frame_end;
    logic [RW-1:0] r_inc;
    logic [AW-1:0] addr0, addr1;
    logic signed [OUT_W-1:0] q0, q1;

    always_comb begin
        dual       = ofm_port0_v & ofm_port1_v;
        collecting = (state == ST_COLLECT);
        r_inc      = r + (dual ? RW'(2) : RW'(1));
        bad_dual   = dual & ((r + RW'(1)) >= RW'(TILE_H));
        accept     = collecting & ~start & ofm_port0_v & ~bad_dual;
        // Any stray valid is flagged, including one colliding with start.
        err        = (ofm_port0_v | ofm_port1_v)
                   & (start | ~collecting
                      | (ofm_port1_v & ~ofm_port0_v) | bad_dual);
        c_last     = (c == CW'(TI - 1));
        row_last   = (r_inc >= RW'(TILE_H));
        tw_last    = (tw == TWW'(N_TW - 1));
        th_last    = (th == THW'(N_TH - 1));
        ch_last    = ((ch + CHW'(1)) == cfg_ch_q);
        frame_end  = accept & c_last & row_last
                   & tw_last & th_last & ch_last;
        addr0      = strip_base + row_off + col_base + AW'(c);
        addr1      = addr0 + AW'(OFM_W);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (start)          state_nxt = ST_COLLECT;
                else if (frame_end) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = start ? ST_COLLECT : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c           <= '0;
            r           <= '0;
            tw          <= '0;
            th          <= '0;
            ch          <= '0;
            strip_base  <= '0;
            row_off     <= '0;
            col_base    <= '0;
            cfg_ch_q    <= '0;
            cfg_shift_q <= '0;
            cfg_relu_q  <= 1'b0;
        end else if (start) begin
            c           <= '0;
            r           <= '0;
            tw          <= '0;
            th          <= '0;
            ch          <= '0;
            strip_base  <= '0;
            row_off     <= '0;
            col_base    <= '0;
            cfg_ch_q    <= cfg_ch;
            cfg_shift_q <= cfg_shift;
            cfg_relu_q  <= cfg_relu;
        end else if (accept) begin
            c <= c_last ? '0 : c + CW'(1);
            if (c_last) begin
                if (!row_last) begin
                    r       <= r_inc;
                    row_off <= row_off
                             + (dual ? AW'(2 * OFM_W) : AW'(OFM_W));
                end else begin
                    r       <= '0;
                    row_off <= '0;
                    if (!tw_last) begin
                        tw       <= tw + TWW'(1);
                        col_base <= col_base + AW'(TI);
                    end else begin
                        tw         <= '0;
                        col_base   <= '0;
                        // Strips of consecutive channels are contiguous.
                        strip_base <= strip_base + AW'(TILE_H * OFM_W);
                        if (!th_last) begin
                            th <= th + THW'(1);
                        end else begin
                            th <= '0;
                            ch <= ch + CHW'(1);
                        end
                    end
                end
            end
        end
    end

    ofm_requant #(.DATA_W(DATA_W), .OUT_W(OUT_W)) u_rq0 (
        .x     (ofm_port0),
        .shift (cfg_shift_q),
        .relu  (cfg_relu_q),
        .y     (q0)
    );

    ofm_requant #(.DATA_W(DATA_W), .OUT_W(OUT_W)) u_rq1 (
        .x     (ofm_port1),
        .shift (cfg_shift_q),
        .relu  (cfg_relu_q),
        .y     (q1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr0_en     <= 1'b0;
            wr1_en     <= 1'b0;
            wr0_addr   <= '0;
            wr1_addr   <= '0;
            wr0_data   <= '0;
            wr1_data   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            wr0_en     <= accept;
            wr1_en     <= accept & dual;
            frame_done <= frame_end;
            if (accept) begin
                wr0_addr <= addr0;
                wr0_data <= q0;
            end
            if (accept && dual) begin
                wr1_addr <= addr1;
                wr1_data <= q1;
            end
            if (start)          busy <= 1'b1;
            else if (frame_end) busy <= 1'b0;
            if (start) proto_err <= err;
            else       proto_err <= proto_err | err;
        end
    end

endmodule
